peripheral_responder: RTL



---
 rtl/peripheral_responder_pkg.sv | 24 ++
 rtl/peripheral_responder_timer_core.sv | 65 ++++++
 rtl/peripheral_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/peripheral_responder_pkg.sv
// Shared constants and types for the memory-mapped peripheral responder.
package peripheral_responder_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

  // Byte offsets inside the 32-byte register window.
  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_DIGI    = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam int unsigned TCON_EN  = 0;
  localparam int unsigned TCON_IE  = 1;
  localparam int unsigned TCON_IRQ = 2;

  typedef struct packed {
    logic th;
    logic tl;
    logic tcon;
  } timer_we_t;

endpackage

// File: rtl/peripheral_responder_timer_core.sv
// TH/TL/TCON timer with reload-on-overflow; CPU writes take priority over ticks.
module timer_core
  import peripheral_responder_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  timer_we_t   we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o
);

  localparam logic TmrIdle = 1'b0;
  localparam logic TmrRun  = 1'b1;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        overflow;

  assign overflow = (tcon_q[TCON_EN] == TmrRun) && (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    if (we_i.th) begin
      th_d = wdata_i;
    end

    if (we_i.tl) begin
      tl_d = wdata_i;
    end else if (overflow) begin
      tl_d = th_q;
    end else if (tcon_q[TCON_EN] == TmrRun) begin
      tl_d = tl_q + 32'd1;
    end

    // A TCON write replaces the sticky flag even in the overflow cycle.
    if (we_i.tcon) begin
      tcon_d = wdata_i[2:0];
    end else if (overflow && tcon_q[TCON_IE]) begin
      tcon_d[TCON_IRQ] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      th_q   <= 32'd0;
      tl_q   <= 32'd0;
      tcon_q <= 3'd0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;

endmodule

// File: rtl/peripheral_responder.sv
// MMIO responder: decodes the register window, holds LED/digit/systick, wraps the timer.
module peripheral_responder
  import peripheral_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
  parameter int unsigned LED_WIDTH  = 8,
  parameter int unsigned DIGI_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           Address,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Hit,
  output logic                  IRQ,
  output logic [LED_WIDTH-1:0]  leds,
  output logic [DIGI_WIDTH-1:0] digits
);

  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic [DIGI_WIDTH-1:0] digi_q, digi_d;
  logic [31:0]           systick_q;
  logic [31:0]           read_data_q, read_data_d;
  logic                  hit_q, hit_d;

  logic [31:0] th, tl;
  logic [2:0]  tcon;
  timer_we_t   timer_we;

  logic        in_window;
  logic [4:0]  offset;
  logic        mapped;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign unused_addr = ^Address[1:0];
  assign in_window   = (Address[31:5] == BASE_ADDR[31:5]);
  assign offset      = {Address[4:2], 2'b00};

  always_comb begin
    mapped = 1'b1;
    rd_mux = 32'd0;
    case (offset)
      OFF_TH:      rd_mux = th;
      OFF_TL:      rd_mux = tl;
      OFF_TCON:    rd_mux = 32'(tcon);
      OFF_LED:     rd_mux = 32'(led_q);
      OFF_DIGI:    rd_mux = 32'(digi_q);
      OFF_SYSTICK: rd_mux = systick_q;
      default:     mapped = 1'b0;
    endcase
  end

  always_comb begin
    timer_we      = '0;
    led_d         = led_q;
    digi_d        = digi_q;
    read_data_d   = read_data_q;
    hit_d         = (MemRead || MemWrite) && in_window && mapped;

    if (MemWrite && in_window) begin
      timer_we.th   = (offset == OFF_TH);
      timer_we.tl   = (offset == OFF_TL);
      timer_we.tcon = (offset == OFF_TCON);
      if (offset == OFF_LED) begin
        led_d = WriteData[LED_WIDTH-1:0];
      end
      if (offset == OFF_DIGI) begin
        digi_d = WriteData[DIGI_WIDTH-1:0];
      end
    end

    // A simultaneous write suppresses the read, leaving ReadData untouched.
    if (MemRead && !MemWrite) begin
      read_data_d = (in_window && mapped) ? rd_mux : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q       <= '0;
      digi_q      <= '0;
      systick_q   <= 32'd0;
      read_data_q <= 32'd0;
      hit_q       <= 1'b0;
    end else begin
      led_q       <= led_d;
      digi_q      <= digi_d;
      systick_q   <= systick_q + 32'd1;
      read_data_q <= read_data_d;
      hit_q       <= hit_d;
    end
  end

  timer_core u_timer_core (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (timer_we),
    .wdata_i (WriteData),
    .th_o    (th),
    .tl_o    (tl),
    .tcon_o  (tcon)
  );

  assign ReadData = read_data_q;
  assign Hit      = hit_q;
  assign IRQ      = tcon[TCON_IRQ];
  assign leds     = led_q;
  assign digits   = digi_q;

endmodule
